// File: rtl/reorder_buffer_pkg.sv
//------------------------------------------------------------------------------
// reorder_buffer_pkg : shared ROB/RS encodings and default widths
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package reorder_buffer_pkg;

  localparam int ROB_WIDTH_DEF = 4;
  localparam int REG_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2,
    ROB_NOP    = 2'd3
  } rob_type_e;

  typedef enum logic [2:0] {
    RS_OP_ALU    = 3'd0,
    RS_OP_BRANCH = 3'd1,
    RS_OP_LOAD   = 3'd2,
    RS_OP_STORE  = 3'd3,
    RS_OP_JUMP   = 3'd4
  } rs_op_e;

  // Branch outcome travels in bit 0 of the result word.
  function automatic logic is_mispredict(input logic taken, input logic pred_taken);
    return taken != pred_taken;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reorder_buffer_query.sv
//------------------------------------------------------------------------------
// rob_query_port : operand readiness lookup with same-cycle result bus bypass
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rob_query_port #(
  parameter int ROB_WIDTH = 4
) (
  input  logic [ROB_WIDTH-1:0]           i_index,
  input  logic [(1<<ROB_WIDTH)-1:0]      i_readyVec,
  input  logic [(32<<ROB_WIDTH)-1:0]     i_valueFlat,
  input  logic                           i_rsUpdate,
  input  logic [ROB_WIDTH-1:0]           i_rsRobId,
  input  logic [31:0]                    i_rsVal,
  input  logic                           i_lsbUpdate,
  input  logic [ROB_WIDTH-1:0]           i_lsbRobId,
  input  logic [31:0]                    i_lsbVal,
  output logic                           o_ready,
  output logic [31:0]                    o_val
);

  always_comb begin
    o_ready = i_readyVec[i_index];
    o_val   = i_valueFlat[{i_index, 5'd0} +: 32];
    if (i_rsUpdate && i_rsRobId == i_index) begin
      o_ready = 1'b1;
      o_val   = i_rsVal;
    end
    if (i_lsbUpdate && i_lsbRobId == i_index) begin
      o_ready = 1'b1;
      o_val   = i_lsbVal;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
//------------------------------------------------------------------------------
// reorder_buffer : circular in-order commit queue with result capture and flush
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEF,
  parameter int REG_WIDTH = REG_WIDTH_DEF
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 issueValid,
  input  logic [1:0]           issueType,
  input  logic [REG_WIDTH-1:0] issueRd,
  input  logic                 issuePredTaken,
  input  logic [31:0]          issueAltPc,
  output logic [ROB_WIDTH-1:0] issueIndex,
  output logic                 full,
  input  logic                 rsUpdate,
  input  logic [ROB_WIDTH-1:0] rsRobId,
  input  logic [31:0]          rsVal,
  input  logic                 lsbUpdate,
  input  logic [ROB_WIDTH-1:0] lsbRobId,
  input  logic [31:0]          lsbVal,
  input  logic [ROB_WIDTH-1:0] query1Index,
  input  logic [ROB_WIDTH-1:0] query2Index,
  output logic                 query1Ready,
  output logic                 query2Ready,
  output logic [31:0]          query1Val,
  output logic [31:0]          query2Val,
  output logic                 commitReg,
  output logic [REG_WIDTH-1:0] commitRd,
  output logic [31:0]          commitVal,
  output logic [ROB_WIDTH-1:0] commitRobId,
  output logic                 commitStore,
  output logic                 clear,
  output logic [31:0]          clearPc
);

  localparam int                 c_DEPTH      = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] c_FULL_LEVEL = (ROB_WIDTH+1)'(c_DEPTH - 1);
  localparam logic [ROB_WIDTH:0] c_MAX_COUNT  = (ROB_WIDTH+1)'(c_DEPTH);

  logic [c_DEPTH-1:0]   r_valid;
  logic [c_DEPTH-1:0]   r_ready;
  logic [c_DEPTH-1:0]   r_predTaken;
  rob_type_e            r_type   [c_DEPTH];
  logic [REG_WIDTH-1:0] r_rd     [c_DEPTH];
  logic [31:0]          r_value  [c_DEPTH];
  logic [31:0]          r_altPc  [c_DEPTH];
  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;

  logic                 r_commitReg;
  logic [REG_WIDTH-1:0] r_commitRd;
  logic [31:0]          r_commitVal;
  logic [ROB_WIDTH-1:0] r_commitRobId;
  logic                 r_commitStore;
  logic                 r_clear;
  logic [31:0]          r_clearPc;

  logic                    w_commit;
  logic                    w_flush;
  logic                    w_issue;
  logic [(32<<ROB_WIDTH)-1:0] w_valueFlat;

  assign w_commit = r_valid[r_head] & r_ready[r_head];
  assign w_flush  = w_commit && (r_type[r_head] == ROB_BRANCH) &&
                    is_mispredict(r_value[r_head][0], r_predTaken[r_head]);
  assign w_issue  = issueValid & ~w_flush;

  assign issueIndex  = r_tail;
  assign full        = (r_count >= c_FULL_LEVEL);
  assign commitReg   = r_commitReg;
  assign commitRd    = r_commitRd;
  assign commitVal   = r_commitVal;
  assign commitRobId = r_commitRobId;
  assign commitStore = r_commitStore;
  assign clear       = r_clear;
  assign clearPc     = r_clearPc;

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      r_valid <= '0;
      r_ready <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      assert (!(issueValid && r_count == c_MAX_COUNT));
      if (w_flush) begin
        r_valid <= '0;
        r_ready <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        for (int i = 0; i < c_DEPTH; i++) begin
          if (r_valid[i] && ((rsUpdate && rsRobId == ROB_WIDTH'(i)) ||
                             (lsbUpdate && lsbRobId == ROB_WIDTH'(i))))
            r_ready[i] <= 1'b1;
        end
        if (w_commit) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + ROB_WIDTH'(1);
        end
        if (w_issue) begin
          r_valid[r_tail] <= 1'b1;
          r_ready[r_tail] <= (issueType == ROB_NOP);
          r_tail          <= r_tail + ROB_WIDTH'(1);
        end
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + (ROB_WIDTH+1)'(1);
          2'b01:   r_count <= r_count - (ROB_WIDTH+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Payload needs no reset: it is only observed behind valid/ready.
  always_ff @(posedge clockIn) begin
    if (!w_flush) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        if (r_valid[i] && rsUpdate && rsRobId == ROB_WIDTH'(i))
          r_value[i] <= rsVal;
        if (r_valid[i] && lsbUpdate && lsbRobId == ROB_WIDTH'(i))
          r_value[i] <= lsbVal;
      end
      if (w_issue) begin
        r_type[r_tail]      <= rob_type_e'(issueType);
        r_rd[r_tail]        <= issueRd;
        r_predTaken[r_tail] <= issuePredTaken;
        r_altPc[r_tail]     <= issueAltPc;
      end
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      r_commitReg   <= 1'b0;
      r_commitRd    <= '0;
      r_commitVal   <= '0;
      r_commitRobId <= '0;
      r_commitStore <= 1'b0;
      r_clear       <= 1'b0;
      r_clearPc     <= '0;
    end else begin
      r_commitReg   <= 1'b0;
      r_commitStore <= 1'b0;
      r_clear       <= 1'b0;
      if (w_commit) begin
        r_commitRobId <= r_head;
        case (r_type[r_head])
          ROB_REG: begin
            r_commitReg <= 1'b1;
            r_commitRd  <= r_rd[r_head];
            r_commitVal <= r_value[r_head];
          end
          ROB_STORE: r_commitStore <= 1'b1;
          ROB_BRANCH: begin
            if (w_flush) begin
              r_clear   <= 1'b1;
              r_clearPc <= r_altPc[r_head];
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_flat
    assign w_valueFlat[gi*32 +: 32] = r_value[gi];
  end

  rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query1 (
    .i_index     (query1Index),
    .i_readyVec  (r_ready),
    .i_valueFlat (w_valueFlat),
    .i_rsUpdate  (rsUpdate),
    .i_rsRobId   (rsRobId),
    .i_rsVal     (rsVal),
    .i_lsbUpdate (lsbUpdate),
    .i_lsbRobId  (lsbRobId),
    .i_lsbVal    (lsbVal),
    .o_ready     (query1Ready),
    .o_val       (query1Val)
  );

  rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query2 (
    .i_index     (query2Index),
    .i_readyVec  (r_ready),
    .i_valueFlat (w_valueFlat),
    .i_rsUpdate  (rsUpdate),
    .i_rsRobId   (rsRobId),
    .i_rsVal     (rsVal),
    .i_lsbUpdate (lsbUpdate),
    .i_lsbRobId  (lsbRobId),
    .i_lsbVal    (lsbVal),
    .o_ready     (query2Ready),
    .o_val       (query2Val)
  );

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
//------------------------------------------------------------------------------
// tb_reorder_buffer : directed self-checking bench for reorder_buffer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        issueValid;
  logic [1:0]  issueType;
  logic [4:0]  issueRd;
  logic        issuePredTaken;
  logic [31:0] issueAltPc;
  logic [3:0]  issueIndex;
  logic        full;
  logic        rsUpdate;
  logic [3:0]  rsRobId;
  logic [31:0] rsVal;
  logic        lsbUpdate;
  logic [3:0]  lsbRobId;
  logic [31:0] lsbVal;
  logic [3:0]  query1Index, query2Index;
  logic        query1Ready, query2Ready;
  logic [31:0] query1Val, query2Val;
  logic        commitReg;
  logic [4:0]  commitRd;
  logic [31:0] commitVal;
  logic [3:0]  commitRobId;
  logic        commitStore;
  logic        clear;
  logic [31:0] clearPc;

  int tests = 0;
  int fails = 0;
  int found;

  always #5 clockIn = ~clockIn;

  reorder_buffer #(.ROB_WIDTH(4), .REG_WIDTH(5)) dut (
    .clockIn(clockIn), .resetIn(resetIn),
    .issueValid(issueValid), .issueType(issueType), .issueRd(issueRd),
    .issuePredTaken(issuePredTaken), .issueAltPc(issueAltPc),
    .issueIndex(issueIndex), .full(full),
    .rsUpdate(rsUpdate), .rsRobId(rsRobId), .rsVal(rsVal),
    .lsbUpdate(lsbUpdate), .lsbRobId(lsbRobId), .lsbVal(lsbVal),
    .query1Index(query1Index), .query2Index(query2Index),
    .query1Ready(query1Ready), .query2Ready(query2Ready),
    .query1Val(query1Val), .query2Val(query2Val),
    .commitReg(commitReg), .commitRd(commitRd), .commitVal(commitVal),
    .commitRobId(commitRobId), .commitStore(commitStore),
    .clear(clear), .clearPc(clearPc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clockIn);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] rd,
                          input logic pred, input logic [31:0] pc);
    issueValid = 1'b1; issueType = t; issueRd = rd;
    issuePredTaken = pred; issueAltPc = pc;
    step();
    issueValid = 1'b0;
  endtask

  task automatic rs_upd(input logic [3:0] id, input logic [31:0] v);
    rsUpdate = 1'b1; rsRobId = id; rsVal = v;
    step();
    rsUpdate = 1'b0;
  endtask

  task automatic lsb_upd(input logic [3:0] id, input logic [31:0] v);
    lsbUpdate = 1'b1; lsbRobId = id; lsbVal = v;
    step();
    lsbUpdate = 1'b0;
  endtask

  task automatic do_reset();
    resetIn = 1'b0;
    issueValid = 1'b0; rsUpdate = 1'b0; lsbUpdate = 1'b0;
    @(negedge clockIn);
    @(negedge clockIn);
    resetIn = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetIn = 1'b1; issueValid = 1'b0; issueType = 2'd0; issueRd = '0;
    issuePredTaken = 1'b0; issueAltPc = '0;
    rsUpdate = 1'b0; rsRobId = '0; rsVal = '0;
    lsbUpdate = 1'b0; lsbRobId = '0; lsbVal = '0;
    query1Index = '0; query2Index = '0;
    #2 resetIn = 1'b0;
    #1;
    chk("rst_commitReg", 32'(commitReg), 0);
    chk("rst_commitStore", 32'(commitStore), 0);
    chk("rst_clear", 32'(clear), 0);
    chk("rst_commitRd", 32'(commitRd), 0);
    chk("rst_commitVal", commitVal, 0);
    chk("rst_clearPc", clearPc, 0);
    chk("rst_issueIndex", 32'(issueIndex), 0);
    chk("rst_full", 32'(full), 0);
    @(negedge clockIn);
    resetIn = 1'b1;
    step();

    // Single REG instruction
    do_issue(ROB_REG, 5'd5, 1'b0, 32'h0);
    chk("t1_issueIndex", 32'(issueIndex), 1);
    rs_upd(4'd0, 32'h1234);
    chk("t1_noCommitYet", 32'(commitReg), 0);
    step();
    chk("t1_commitReg", 32'(commitReg), 1);
    chk("t1_commitRd", 32'(commitRd), 5);
    chk("t1_commitVal", commitVal, 32'h1234);
    chk("t1_commitRobId", 32'(commitRobId), 0);
    step();
    chk("t1_pulseEnds", 32'(commitReg), 0);

    // Out-of-order completion, in-order commit
    do_reset();
    do_issue(ROB_REG, 5'd1, 1'b0, 32'h0);
    do_issue(ROB_REG, 5'd2, 1'b0, 32'h0);
    rs_upd(4'd1, 32'd7);
    chk("t2_holdYoung", 32'(commitReg), 0);
    rs_upd(4'd0, 32'd9);
    step();
    chk("t2_c0_reg", 32'(commitReg), 1);
    chk("t2_c0_rd", 32'(commitRd), 1);
    chk("t2_c0_val", commitVal, 9);
    step();
    chk("t2_c1_reg", 32'(commitReg), 1);
    chk("t2_c1_rd", 32'(commitRd), 2);
    chk("t2_c1_val", commitVal, 7);
    chk("t2_c1_id", 32'(commitRobId), 1);

    // STORE release and NOP retire
    do_reset();
    do_issue(ROB_STORE, 5'd0, 1'b0, 32'h0);
    lsb_upd(4'd0, 32'hDEAD);
    step();
    chk("t3_commitStore", 32'(commitStore), 1);
    chk("t3_storeNoReg", 32'(commitReg), 0);
    do_issue(ROB_NOP, 5'd0, 1'b0, 32'h0);
    chk("t3_storePulseEnds", 32'(commitStore), 0);
    step();
    chk("t3_nopRobId", 32'(commitRobId), 1);
    chk("t3_nopNoReg", 32'(commitReg), 0);
    chk("t3_nopNoStore", 32'(commitStore), 0);

    // Fill to full, drain one, wrap the tail
    do_reset();
    for (int i = 0; i < 14; i++) do_issue(ROB_REG, 5'(i), 1'b0, 32'h0);
    chk("t4_notFull14", 32'(full), 0);
    do_issue(ROB_REG, 5'd14, 1'b0, 32'h0);
    chk("t4_full15", 32'(full), 1);
    rs_upd(4'd0, 32'h50);
    chk("t4_stillFull", 32'(full), 1);
    step();
    chk("t4_c0_val", commitVal, 32'h50);
    chk("t4_fullDrop", 32'(full), 0);
    chk("t4_tail15", 32'(issueIndex), 15);
    do_issue(ROB_REG, 5'd15, 1'b0, 32'h0);
    rs_upd(4'd1, 32'h61);
    step();
    chk("t4_c1_id", 32'(commitRobId), 1);
    chk("t4_tailWrap", 32'(issueIndex), 0);
    do_issue(ROB_REG, 5'd20, 1'b0, 32'h0);
    chk("t4_tailAfterWrap", 32'(issueIndex), 1);
    for (int i = 2; i < 16; i++) rs_upd(4'(i), 32'h100 + 32'(i));
    rs_upd(4'd0, 32'h100);
    found = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (commitReg && commitRobId == 4'd0) begin
        found = 1;
        break;
      end
    end
    chk("t4_wrapCommitSeen", 32'(found), 1);
    chk("t4_wrapRd", 32'(commitRd), 20);
    chk("t4_wrapVal", commitVal, 32'h100);
    step();
    chk("t4_emptyFull", 32'(full), 0);

    // Mispredicted branch flushes younger work
    do_reset();
    do_issue(ROB_BRANCH, 5'd0, 1'b0, 32'h100);
    do_issue(ROB_REG, 5'd7, 1'b0, 32'h0);
    rs_upd(4'd1, 32'h77);
    rs_upd(4'd0, 32'h1);
    do_issue(ROB_REG, 5'd9, 1'b0, 32'h0);
    chk("t5_clear", 32'(clear), 1);
    chk("t5_clearPc", clearPc, 32'h100);
    chk("t5_clearRobId", 32'(commitRobId), 0);
    chk("t5_noReg", 32'(commitReg), 0);
    chk("t5_tailReset", 32'(issueIndex), 0);
    query1Index = 4'd1;
    #1;
    chk("t5_youngFlushed", 32'(query1Ready), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_clearEnds", 32'(clear), 0);
      chk("t5_youngNeverCommits", 32'(commitReg), 0);
    end

    // Query bypass priority
    do_reset();
    for (int i = 0; i < 4; i++) do_issue(ROB_REG, 5'(i), 1'b0, 32'h0);
    query1Index = 4'd3; query2Index = 4'd2;
    #1;
    chk("t6_q1NotReady", 32'(query1Ready), 0);
    rsUpdate = 1'b1; rsRobId = 4'd3; rsVal = 32'hAB;
    #1;
    chk("t6_rsBypassRdy", 32'(query1Ready), 1);
    chk("t6_rsBypassVal", query1Val, 32'hAB);
    chk("t6_q2Untouched", 32'(query2Ready), 0);
    lsbUpdate = 1'b1; lsbRobId = 4'd3; lsbVal = 32'hCD;
    #1;
    chk("t6_lsbPriority", query1Val, 32'hCD);
    step();
    rsUpdate = 1'b0; lsbUpdate = 1'b0;
    query2Index = 4'd3;
    #1;
    chk("t6_storedRdy", 32'(query1Ready), 1);
    chk("t6_storedVal", query1Val, 32'hCD);
    chk("t6_q2StoredVal", query2Val, 32'hCD);

    // Asynchronous reset mid-stream
    do_reset();
    do_issue(ROB_NOP, 5'd0, 1'b0, 32'h0);
    do_issue(ROB_REG, 5'd3, 1'b0, 32'h0);
    rs_upd(4'd1, 32'h33);
    step();
    chk("t7_pending", 32'(commitReg), 1);
    chk("t7_pendingId", 32'(commitRobId), 1);
    resetIn = 1'b0;
    #1;
    chk("t7_rstReg", 32'(commitReg), 0);
    chk("t7_rstRd", 32'(commitRd), 0);
    chk("t7_rstVal", commitVal, 0);
    chk("t7_rstId", 32'(commitRobId), 0);
    chk("t7_rstIdx", 32'(issueIndex), 0);
    @(negedge clockIn);
    resetIn = 1'b1;
    step();
    chk("t7_idxAfter", 32'(issueIndex), 0);
    chk("t7_regAfter", 32'(commitReg), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
